data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 40, number of 32-bit words in the array.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request accept and response (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-012 SHALL have port rsp_rdata  output  32  load data, or echoed store data for writes.
REQ-013 SHALL have port rsp_error  output  1  request was misaligned or out of range.
REQ-014 SHALL have port acc_count  output  16  count of completed responses, saturating.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready; capture req_write, req_addr, req_wdata in that same edge.
REQ-017 SHALL go IDLE->WAIT on accept when LATENCY>0, loading a down-counter so WAIT lasts exactly LATENCY cycles; SHALL go IDLE->RESP directly when LATENCY=0.
REQ-018 SHALL assert rsp_valid in RESP only; first rsp_valid-high cycle begins LATENCY+1 rising edges after the accept edge.
REQ-019 SHALL flag error when captured addr[1:0] != 0 or word index >= DEPTH; error requests SHALL NOT modify the array and SHALL return rsp_rdata = 0, rsp_error = 1.
REQ-020 SHALL perform a valid store on the edge entering RESP; rsp_rdata = captured wdata, rsp_error = 0.
REQ-021 SHALL read the array on the edge entering RESP for a valid load; rsp_rdata = mem[index], rsp_error = 0.
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_error stable in RESP until rsp_ready = 1; on rsp_valid && rsp_ready SHALL return to IDLE on that edge.
REQ-023 SHALL NOT accept a new request in the same edge the response completes (req_ready low in RESP); next accept earliest one cycle later.
REQ-024 SHALL ignore req_valid and input changes while in WAIT or RESP.
REQ-025 SHALL increment acc_count on every response handshake (error or not), saturating at 16'hFFFF.
REQ-026 SHALL power up with mem[0..20] = 0,19,36,51,64,75,84,91,96,99,100,99,96,91,84,75,64,51,36,19,0 and all other words 0.

Reset
REQ-027 SHALL, while reset = 0, force state IDLE, req_ready = 1 (once released), rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, acc_count = 0, wait counter = 0.
REQ-028 SHALL NOT alter array contents on reset; a store pending in WAIT when reset asserts SHALL be discarded and not written.
REQ-029 SHALL drive req_ready = 0 while reset is asserted; first accept is possible on the first rising edge after reset deasserts.

Verification
REQ-030 Load, LATENCY=2: accept addr 0x28, rsp_ready=1 -> rsp_valid high 3 edges after accept, rsp_rdata=100, rsp_error=0, acc_count=1.
REQ-031 Store then load: store 0x0000ABCD to addr 0x50 (index 20), then load 0x50 -> store rsp_rdata=0xABCD; load rsp_rdata=0x0000ABCD.
REQ-032 Error cases: load addr 0x29 and load addr 0xA0 (index 40) -> rsp_error=1, rsp_rdata=0; store to 0xA0 leaves all words unchanged.
REQ-033 Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid rises -> rsp_valid/rsp_rdata stable, req_ready=0, second req_valid ignored; completes when rsp_ready=1.
REQ-034 Reset mid-store: store 0x1234 to 0x04, assert reset in WAIT -> outputs at reset values, mem[1] still 19, acc_count=0.
REQ-035 LATENCY=0 back-to-back: two loads with rsp_ready=1 -> each rsp_valid one edge after accept; accepts 2 cycles apart minimum.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word memory responder with fixed response latency
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   req_*      : request channel (valid/ready, write flag, byte address, store data)
//   rsp_*      : response channel (valid/ready, read or echoed store data, error flag)
//   acc_count  : saturating count of completed response handshakes
module data_mem_responder #(
    parameter int DEPTH   = 40,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [15:0] acc_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic        accept, enter_resp, eff_write, eff_err, mem_we;
    logic [31:0] eff_addr, eff_wdata, rd_data;
    logic [29:0] eff_idx;
    // Power-up contents only; reset never touches the array.
    logic [31:0] mem [DEPTH] = '{
        1: 32'd19, 2: 32'd36, 3: 32'd51, 4: 32'd64, 5: 32'd75, 6: 32'd84, 7: 32'd91,
        8: 32'd96, 9: 32'd99, 10: 32'd100, 11: 32'd99, 12: 32'd96, 13: 32'd91,
        14: 32'd84, 15: 32'd75, 16: 32'd64, 17: 32'd51, 18: 32'd36, 19: 32'd19,
        default: 32'd0
    };
    assign req_ready = (state == IDLE) && reset;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    // With zero latency the array is accessed on the accept edge itself, so the
    // live request inputs stand in for the not-yet-captured registers.
    assign eff_write  = (state == IDLE) ? req_write : wr_q;
    assign eff_addr   = (state == IDLE) ? req_addr : addr_q;
    assign eff_wdata  = (state == IDLE) ? req_wdata : wdata_q;
    assign eff_idx    = eff_addr[31:2];
    assign eff_err    = (eff_addr[1:0] != 2'b00) || (eff_idx >= 30'(DEPTH));
    assign enter_resp = (state == IDLE) ? (accept && LATENCY == 0) : (state == WAIT && wait_cnt == 4'd1);
    assign mem_we     = enter_resp && eff_write && !eff_err;
    assign rd_data    = eff_err ? 32'd0 : eff_write ? eff_wdata : mem[eff_idx[AW-1:0]];
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next    = (LATENCY == 0) ? RESP : WAIT;
                    wait_cnt_next = 4'(LATENCY);
                end
            end
            WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                state_next    = (wait_cnt == 4'd1) ? RESP : WAIT;
            end
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
            acc_count <= 16'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rsp_rdata <= rd_data;
                rsp_error <= eff_err;
            end
            if (rsp_valid && rsp_ready && acc_count != 16'hFFFF)
                acc_count <= acc_count + 16'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[eff_idx[AW-1:0]] <= eff_wdata;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: checks a LATENCY=2 and a LATENCY=0 responder against a transaction-level model
module tb_data_mem_responder;
    logic        clk = 0;
    logic        reset = 0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_error [2];
    logic [15:0] acc_count [2];
    int n_cmp = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, g, $time, act, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : m
        localparam int L = (g == 0) ? 2 : 0;
        data_mem_responder #(.DEPTH(40), .LATENCY(L)) dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
            .rsp_error(rsp_error[g]), .acc_count(acc_count[g])
        );
        // Model: one outstanding request, visible from edge (accept edge + L) until handshake.
        logic [31:0] mm [40];
        bit          pend = 0, wr = 0, e_err = 0;
        int          acc_cyc = 0, cyc = 0, cnt = 0, w_idx = 0;
        logic [31:0] e_rdata = 0, w_data = 0;
        initial for (int i = 0; i < 40; i++) mm[i] = (i <= 20) ? 32'(i * (20 - i)) : 32'd0;
        always @(posedge clk) begin
            automatic bit vis = pend && cyc >= acc_cyc + L;
            automatic int idx = int'(req_addr[g][31:2]);
            if (!reset) begin
                pend = 0;
                cnt  = 0;
            end else if (vis && rsp_ready[g]) begin
                pend = 0;
                cnt  = (cnt == 65535) ? cnt : cnt + 1;
            end else if (!pend && req_valid[g]) begin
                pend    = 1;
                acc_cyc = cyc + 1;
                wr      = req_write[g];
                e_err   = (req_addr[g][1:0] != 2'b00) || idx >= 40;
                e_rdata = e_err ? 32'd0 : wr ? req_wdata[g] : mm[idx];
                w_idx   = idx;
                w_data  = req_wdata[g];
            end
            if (pend && wr && !e_err && cyc + 1 == acc_cyc + L) mm[w_idx] = w_data;
            cyc++;
        end
        always @(negedge clk) begin
            automatic bit exp_v = pend && cyc >= acc_cyc + L;
            chk("rsp_valid", g, 32'(rsp_valid[g]), 32'(exp_v));
            chk("req_ready", g, 32'(req_ready[g]), 32'(reset && !pend));
            chk("acc_count", g, 32'(acc_count[g]), 32'(cnt));
            if (exp_v) begin
                chk("rsp_rdata", g, rsp_rdata[g], e_rdata);
                chk("rsp_error", g, 32'(rsp_error[g]), 32'(e_err));
            end
            if (!reset) begin
                chk("rst_rdata", g, rsp_rdata[g], 32'd0);
                chk("rst_error", g, 32'(rsp_error[g]), 32'd0);
            end
        end
    end
    task automatic txn(input int g, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        int n = 0;
        @(negedge clk); #1;
        req_valid[g] = 1; req_write[g] = wr; req_addr[g] = addr; req_wdata[g] = wdata;
        while (!req_ready[g] && n < 20) begin @(negedge clk); #1; n++; end
        chk("accept_wait", g, 32'(req_ready[g]), 32'd1);
        @(posedge clk);
        @(negedge clk); #1;
        req_valid[g] = 0;
        lat = 0;
        while (!rsp_valid[g] && lat < 20) begin @(negedge clk); lat++; end
        rdata = rsp_rdata[g];
        err   = rsp_error[g];
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, highs, n;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 0; req_write[g] = 0; req_addr[g] = 0; req_wdata[g] = 0; rsp_ready[g] = 1;
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 0, 32'(req_ready[0]), 32'd0);
        #1 reset = 1;
        // load 0x28, LATENCY=2
        txn(0, 0, 32'h28, 0, rd, er, lat);
        chk("lat2", 0, 32'(lat), 32'd2);
        chk("load28", 0, rd, 32'd100);
        chk("load28_err", 0, 32'(er), 32'd0);
        chk("cnt1", 0, 32'(acc_count[0]), 32'd1);
        // store then load index 20
        txn(0, 1, 32'h50, 32'h0000ABCD, rd, er, lat);
        chk("store50", 0, rd, 32'h0000ABCD);
        txn(0, 0, 32'h50, 0, rd, er, lat);
        chk("load50", 0, rd, 32'h0000ABCD);
        // error cases
        txn(0, 0, 32'h29, 0, rd, er, lat);
        chk("mis_err", 0, 32'(er), 32'd1);
        chk("mis_data", 0, rd, 32'd0);
        txn(0, 0, 32'hA0, 0, rd, er, lat);
        chk("oor_err", 0, 32'(er), 32'd1);
        chk("oor_data", 0, rd, 32'd0);
        txn(0, 1, 32'hA0, 32'hDEADBEEF, rd, er, lat);
        chk("oor_st_err", 0, 32'(er), 32'd1);
        chk("oor_st_data", 0, rd, 32'd0);
        // backpressure: load index 5, hold rsp_ready low for 5 cycles
        rsp_ready[0] = 0;
        @(negedge clk); #1;
        req_valid[0] = 1; req_write[0] = 0; req_addr[0] = 32'h14;
        @(posedge clk);
        @(negedge clk); #1;
        req_valid[0] = 0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin @(negedge clk); #1; n++; end
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1; req_addr[0] = 32'h2C;
            @(negedge clk);
            chk("bp_valid", 0, 32'(rsp_valid[0]), 32'd1);
            chk("bp_rdata", 0, rsp_rdata[0], 32'd75);
            chk("bp_ready", 0, 32'(req_ready[0]), 32'd0);
            #1;
        end
        req_valid[0] = 0; rsp_ready[0] = 1;
        @(negedge clk);
        chk("bp_done", 0, 32'(rsp_valid[0]), 32'd0);
        chk("bp_cnt", 0, 32'(acc_count[0]), 32'd7);
        // reset while a store waits
        #1;
        req_valid[0] = 1; req_write[0] = 1; req_addr[0] = 32'h04; req_wdata[0] = 32'h1234;
        @(posedge clk);
        @(negedge clk); #1;
        req_valid[0] = 0; req_write[0] = 0;
        reset = 0;
        #1;
        chk("mid_rst_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("mid_rst_ready", 0, 32'(req_ready[0]), 32'd0);
        chk("mid_rst_cnt", 0, 32'(acc_count[0]), 32'd0);
        chk("mid_rst_rdata", 0, rsp_rdata[0], 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1;
        // sweep all words: mem[1] must still be 19, index 20 holds the earlier store
        for (int i = 0; i < 40; i++) begin
            txn(0, 0, 32'(i * 4), 0, rd, er, lat);
            chk("sweep", i, rd, (i == 20) ? 32'h0000ABCD : (i < 20) ? 32'(i * (20 - i)) : 32'd0);
        end
        // LATENCY=0 instance
        txn(1, 0, 32'h28, 0, rd, er, lat);
        chk("lat0", 1, 32'(lat), 32'd0);
        chk("lat0_load", 1, rd, 32'd100);
        @(negedge clk); #1;
        req_valid[1] = 1; req_write[1] = 0; req_addr[1] = 32'h0C;
        highs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b2b_pattern", 1, 32'(rsp_valid[1]), 32'(k % 2 == 0));
            highs += int'(rsp_valid[1]);
        end
        #1 req_valid[1] = 0;
        chk("b2b_count", 1, 32'(highs), 32'd3);
        @(negedge clk);
        chk("b2b_acc", 1, 32'(acc_count[1]), 32'd4);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
